// File: rtl/vga_vram_arbiter_if.sv
// Writer-side request/response bus of the VGA video RAM arbiter.
// wr_* is a valid/ready request (held until wr_valid && wr_ready); rd_* is a one-cycle read response.
interface vga_vram_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
);
  logic              wr_valid;
  logic              wr_ready;
  logic              wr_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_valid, wr_we, wr_addr, wr_data,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_we, wr_addr, wr_data,
    output wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Shares one single-port synchronous video RAM between VGA scanout (priority in active video)
// and a pixel writer that is served in blanking; re-times syncs to match fetched pixels.
module vga_vram_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 521,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              hsync_in,
  input  logic              vsync_in,
  vga_vram_arbiter_if.slave wbus,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] pix_rgb,
  output logic              pix_de,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              err_oob,
  output logic [15:0]       stall_cnt
);

  localparam logic [9:0]        H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0]        H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]        V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0]        V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] PIX_CNT = ADDR_W'(H_ACTIVE * V_ACTIVE);

  logic              scan_slot;
  logic              frame_end;
  logic              wr_accept;
  logic              wr_oob;
  logic              stall_evt;
  logic [ADDR_W-1:0] scan_addr;

  // Read-response owner pipeline: one stage, matching the RAM's 1-cycle read latency.
  logic              pend_valid;
  logic              pend_writer;
  logic              pend_oob;

  logic              hs_d1;
  logic              vs_d1;

  assign scan_slot     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign frame_end     = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign wbus.wr_ready = !rst && !scan_slot;
  assign wr_accept     = wbus.wr_valid && wbus.wr_ready;
  assign wr_oob        = wbus.wr_addr >= PIX_CNT;
  assign stall_evt     = wbus.wr_valid && !wbus.wr_ready;

  // RAM port mux: scanout owns every active-video cycle, the writer gets the rest.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!rst) begin
      if (scan_slot) begin
        ram_en   = 1'b1;
        ram_addr = scan_addr;
      end else if (wr_accept && !wr_oob) begin
        ram_en    = 1'b1;
        ram_we    = wbus.wr_we;
        ram_addr  = wbus.wr_addr;
        ram_wdata = wbus.wr_we ? wbus.wr_data : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_addr <= '0;
    end else if (frame_end) begin
      scan_addr <= '0;
    end else if (scan_slot) begin
      scan_addr <= scan_addr + ADDR_W'(1);
    end
  end

  // An out-of-range writer read occupies a response slot but never touches the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid  <= 1'b0;
      pend_writer <= 1'b0;
      pend_oob    <= 1'b0;
    end else begin
      pend_valid  <= scan_slot || (wr_accept && !wbus.wr_we);
      pend_writer <= !scan_slot;
      pend_oob    <= wr_accept && !wbus.wr_we && wr_oob;
    end
  end

  assign wbus.rd_valid = !rst && pend_valid && pend_writer;
  assign wbus.rd_data  = (wbus.rd_valid && !pend_oob) ? ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_rgb <= '0;
      pix_de  <= 1'b0;
    end else if (pend_valid && !pend_writer) begin
      pix_rgb <= ram_rdata;
      pix_de  <= 1'b1;
    end else begin
      pix_rgb <= '0;
      pix_de  <= 1'b0;
    end
  end

  // Two stages so syncs land on the same cycle as the pixel fetched for them.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_d1     <= 1'b1;
      vs_d1     <= 1'b1;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      hs_d1     <= hsync_in;
      vs_d1     <= vsync_in;
      hsync_out <= hs_d1;
      vsync_out <= vs_d1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_oob <= 1'b0;
    end else if (wr_accept && wr_oob) begin
      err_oob <= 1'b1;
    end
  end

  // Frame-end clear takes precedence over a stall in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (frame_end) begin
      stall_cnt <= '0;
    end else if (stall_evt && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  scan_owns_ram: assert property (@(posedge clk) disable iff (rst)
    scan_slot |-> (ram_en && !ram_we && (ram_addr == scan_addr)));

  writer_never_in_slot: assert property (@(posedge clk) disable iff (rst)
    scan_slot |-> !wbus.wr_ready);

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Bench for vga_vram_arbiter on a reduced raster: RAM model, timing driver, writer driver,
// and a per-cycle comparison against a frame-level reference of pixels, reads and counters.
module tb_vga_vram_arbiter;

  localparam int HA  = 32;
  localparam int HT  = 40;
  localparam int VA  = 12;
  localparam int VT  = 14;
  localparam int AW  = 19;
  localparam int DW  = 12;
  localparam int PIX = HA * VA;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [9:0]    h_cnt = '0;
  logic [9:0]    v_cnt = '0;
  logic          hsync_in = 1'b1;
  logic          vsync_in = 1'b1;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] pix_rgb;
  logic          pix_de;
  logic          hsync_out;
  logic          vsync_out;
  logic          err_oob;
  logic [15:0]   stall_cnt;

  int checks = 0;
  int errors = 0;

  vga_vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) wbus ();

  vga_vram_arbiter #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .wbus(wbus),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .pix_rgb(pix_rgb), .pix_de(pix_de),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .err_oob(err_oob), .stall_cnt(stall_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 37 + 5);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- single-port RAM, 1-cycle read ----------------
  logic [DW-1:0] ram_mem [PIX];
  bit            ram_init = 1'b0;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < PIX; i++) ram_mem[i] = init_val(i);
      ram_init = 1'b1;
    end else if (ram_en && (int'(ram_addr) < PIX)) begin
      if (ram_we) ram_mem[int'(ram_addr)] = ram_wdata;
      else        ram_rdata <= ram_mem[int'(ram_addr)];
    end
  end

  // ---------------- reference model and compare ----------------
  typedef struct packed {
    logic          de;
    logic [DW-1:0] rgb;
    logic          rv;
    logic [DW-1:0] rd;
    logic          hs;
    logic          vs;
  } rec_t;

  localparam rec_t NEUTRAL = '{de: 1'b0, rgb: '0, rv: 1'b0, rd: '0, hs: 1'b1, vs: 1'b1};

  rec_t          p1 = NEUTRAL;
  rec_t          p2 = NEUTRAL;
  logic [DW-1:0] ref_mem [PIX];
  bit            ref_init = 1'b0;
  bit            err_m = 1'b0;
  int            stall_m = 0;

  always @(negedge clk) begin : compare
    rec_t cur;
    int   h, v, a;
    bit   slot, fend, rdy, acc, oob;
    if (!ref_init) begin
      for (int i = 0; i < PIX; i++) ref_mem[i] = init_val(i);
      ref_init = 1'b1;
    end
    h    = int'(h_cnt);
    v    = int'(v_cnt);
    a    = int'(wbus.wr_addr);
    slot = (h < HA) && (v < VA);
    fend = (h == HT - 1) && (v == VT - 1);
    rdy  = !rst && !slot;
    acc  = wbus.wr_valid && rdy;
    oob  = a >= PIX;

    if (rst) begin
      chk("rst_wr_ready",  32'(wbus.wr_ready), 0);
      chk("rst_ram_en",    32'(ram_en), 0);
      chk("rst_ram_we",    32'(ram_we), 0);
      chk("rst_ram_addr",  32'(ram_addr), 0);
      chk("rst_ram_wdata", 32'(ram_wdata), 0);
      chk("rst_rd_valid",  32'(wbus.rd_valid), 0);
      chk("rst_rd_data",   32'(wbus.rd_data), 0);
    end else begin
      chk("wr_ready", 32'(wbus.wr_ready), 32'(rdy));
      if (slot) begin
        chk("scan_en",   32'(ram_en), 1);
        chk("scan_we",   32'(ram_we), 0);
        chk("scan_addr", 32'(ram_addr), 32'(v * HA + h));
      end else if (acc && !oob) begin
        chk("wr_en",   32'(ram_en), 1);
        chk("wr_we",   32'(ram_we), 32'(wbus.wr_we));
        chk("wr_addr", 32'(ram_addr), 32'(a));
        if (wbus.wr_we) chk("wr_wdata", 32'(ram_wdata), 32'(wbus.wr_data));
      end else begin
        chk("idle_en", 32'(ram_en), 0);
        chk("idle_we", 32'(ram_we), 0);
      end
      chk("rd_valid", 32'(wbus.rd_valid), 32'(p1.rv));
      if (p1.rv) chk("rd_data", 32'(wbus.rd_data), 32'(p1.rd));
    end
    chk("pix_de",    32'(pix_de), 32'(p2.de));
    chk("pix_rgb",   32'(pix_rgb), 32'(p2.rgb));
    chk("hsync_out", 32'(hsync_out), 32'(p2.hs));
    chk("vsync_out", 32'(vsync_out), 32'(p2.vs));
    chk("err_oob",   32'(err_oob), 32'(err_m));
    chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));

    cur = NEUTRAL;
    if (!rst) begin
      cur.hs = hsync_in;
      cur.vs = vsync_in;
      if (slot) begin
        cur.de  = 1'b1;
        cur.rgb = ref_mem[v * HA + h];
      end
      if (acc && !wbus.wr_we) begin
        cur.rv = 1'b1;
        cur.rd = oob ? '0 : ref_mem[a];
      end
      if (acc && wbus.wr_we && !oob) ref_mem[a] = wbus.wr_data;
      if (acc && oob) err_m = 1'b1;
    end
    if (rst) err_m = 1'b0;
    if (rst || fend) stall_m = 0;
    else if (wbus.wr_valid && !rdy && stall_m < 65535) stall_m++;
    if (rst) begin
      p2 = NEUTRAL;
      p1 = NEUTRAL;
    end else begin
      p2 = p1;
      p1 = cur;
    end
  end

  // ---------------- drivers ----------------
  int            cur_h = 0;
  int            cur_v = 0;
  int            acc_h = -1;
  logic          rq_valid = 1'b0;
  logic          rq_we = 1'b0;
  logic [AW-1:0] rq_addr = '0;
  logic [DW-1:0] rq_data = '0;

  task automatic drive();
    h_cnt         = 10'(cur_h);
    v_cnt         = 10'(cur_v);
    hsync_in      = !((cur_h >= HA + 2) && (cur_h < HA + 6));
    vsync_in      = !(cur_v == VA + 1);
    wbus.wr_valid = rq_valid;
    wbus.wr_we    = rq_we;
    wbus.wr_addr  = rq_addr;
    wbus.wr_data  = rq_data;
  endtask

  task automatic advance(input bit step);
    @(posedge clk);
    #1;
    if (rq_valid && !rst && !((cur_h < HA) && (cur_v < VA))) begin
      rq_valid = 1'b0;
      acc_h    = cur_h;
    end
    if (step) begin
      if (cur_h == HT - 1) begin
        cur_h = 0;
        cur_v = (cur_v == VT - 1) ? 0 : cur_v + 1;
      end else begin
        cur_h++;
      end
    end
  endtask

  task automatic tick();
    drive();
    advance(1'b1);
  endtask

  task automatic run_to(input int h, input int v);
    for (int n = 0; n < HT * VT && !(cur_h == h && cur_v == v); n++) tick();
  endtask

  task automatic writer_op(input bit we, input int addr, input logic [DW-1:0] data);
    rq_we    = we;
    rq_addr  = AW'(addr);
    rq_data  = data;
    rq_valid = 1'b1;
    for (int n = 0; n < 2 * HT && rq_valid; n++) tick();
  endtask

  // Reset is applied with the timing position parked at frame end.
  task automatic do_reset(input int n, input bit lit);
    rq_valid = 1'b0;
    rst      = 1'b1;
    cur_h    = HT - 1;
    cur_v    = VT - 1;
    repeat (n - 1) begin
      drive();
      advance(1'b0);
    end
    drive();
    if (lit) begin
      @(negedge clk);
      chk("lit_rst_wr_ready", 32'(wbus.wr_ready), 0);
      chk("lit_rst_ram_en",   32'(ram_en), 0);
      chk("lit_rst_rd_valid", 32'(wbus.rd_valid), 0);
      chk("lit_rst_pix_de",   32'(pix_de), 0);
      chk("lit_rst_pix_rgb",  32'(pix_rgb), 0);
      chk("lit_rst_hsync",    32'(hsync_out), 1);
      chk("lit_rst_vsync",    32'(vsync_out), 1);
      chk("lit_rst_err_oob",  32'(err_oob), 0);
      chk("lit_rst_stall",    32'(stall_cnt), 0);
    end
    advance(1'b0);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    wbus.wr_valid = 1'b0;
    wbus.wr_we    = 1'b0;
    wbus.wr_addr  = '0;
    wbus.wr_data  = '0;
    @(posedge clk);
    #1;
    do_reset(3, 1'b1);

    // Frame 0 vblank: write pixel 5, then out-of-range write and read.
    run_to(0, VA + 1);
    writer_op(1'b1, 5, 12'hF80);
    writer_op(1'b1, PIX, 12'hABC);
    drive();
    @(negedge clk);
    chk("lit_oob_err", 32'(err_oob), 1);
    advance(1'b1);
    writer_op(1'b0, PIX + 3, 12'h000);
    drive();
    @(negedge clk);
    chk("lit_oob_rd_valid", 32'(wbus.rd_valid), 1);
    chk("lit_oob_rd_data",  32'(wbus.rd_data), 0);
    advance(1'b1);

    // Frame 1: wrap to address 0, then the written pixel comes out two cycles after its fetch.
    run_to(0, 0);
    drive();
    @(negedge clk);
    chk("lit_wrap_addr",  32'(ram_addr), 0);
    chk("lit_wrap_stall", 32'(stall_cnt), 0);
    advance(1'b1);
    run_to(5, 0);
    drive();
    @(negedge clk);
    chk("lit_fetch_addr", 32'(ram_addr), 5);
    advance(1'b1);
    tick();
    drive();
    @(negedge clk);
    chk("lit_pix_rgb", 32'(pix_rgb), 32'h0F80);
    chk("lit_pix_de",  32'(pix_de), 1);
    advance(1'b1);

    // Writer request held across the end of active video on line 2.
    run_to(HA - 10, 2);
    acc_h = -1;
    writer_op(1'b1, 40, 12'h123);
    chk("lit_prio_accept_h", 32'(acc_h), 32'(HA));
    drive();
    @(negedge clk);
    chk("lit_prio_stall", 32'(stall_cnt), 10);
    advance(1'b1);

    // Hblank readback of pixel 5.
    run_to(HA + 2, 3);
    writer_op(1'b0, 5, 12'h000);
    drive();
    @(negedge clk);
    chk("lit_rb_valid", 32'(wbus.rd_valid), 1);
    chk("lit_rb_data",  32'(wbus.rd_data), 32'h0F80);
    advance(1'b1);

    run_to(HA - 1, VA - 1);
    drive();
    @(negedge clk);
    chk("lit_last_addr", 32'(ram_addr), 32'(PIX - 1));
    advance(1'b1);

    // Reset right behind an accepted read: its response must be dropped.
    run_to(HA + 3, VA);
    writer_op(1'b0, 7, 12'h000);
    do_reset(3, 1'b1);

    // Randomized traffic over several frames.
    for (int f = 0; f < 10; f++) begin
      for (int n = 0; n < HT * VT; n++) begin
        if (!rq_valid && ($urandom_range(0, 2) == 0)) begin
          rq_we    = 1'($urandom_range(0, 1));
          rq_addr  = ($urandom_range(0, 15) == 0) ? AW'(PIX + int'($urandom_range(0, 50)))
                                                  : AW'($urandom_range(0, PIX - 1));
          rq_data  = DW'($urandom);
          rq_valid = 1'b1;
        end
        if (cur_h == 0 && cur_v == 0) begin
          drive();
          @(negedge clk);
          chk("lit_frame_addr",  32'(ram_addr), 0);
          chk("lit_frame_stall", 32'(stall_cnt), 0);
          advance(1'b1);
        end else begin
          tick();
        end
      end
    end

    rq_valid = 1'b0;
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
